// File: rtl/apb_ucpd_pkg.sv
// ============================================================================
// Module  : apb_ucpd_pkg
// Brief   : Shared constants for the UCPD receive buffer.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_ucpd_pkg;
  localparam int         C_RXB_ST_W     = 4;
  localparam logic [3:0] C_RXB_IDLE     = 4'b0001;
  localparam logic [3:0] C_RXB_RECV     = 4'b0010;
  localparam logic [3:0] C_RXB_DRAIN    = 4'b0100;
  localparam logic [3:0] C_RXB_DONE     = 4'b1000;
  localparam int         C_RX_DEPTH_DEF = 4;
  localparam int         C_RX_PAYSZ_W   = 10;
  localparam logic [9:0] C_RX_PAYSZ_MAX = 10'd1023;
endpackage

`default_nettype wire

// File: rtl/apb_ucpd_rx_buf_if.sv
// ============================================================================
// Module  : apb_ucpd_rx_buf_if
// Brief   : Decoder-side and register-file-side signals of the RX buffer.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface apb_ucpd_rx_buf_if #(
  parameter int CNT_W = 3
);
  logic             ucpden;
  logic             rx_sop;
  logic             rx_byte_vld;
  logic [7:0]       rx_byte;
  logic             rx_eop;
  logic             rx_crc_ok;
  logic             rx_hrst_det;
  logic             rxdr_rd;
  logic             rxmsgend_clr;
  logic             rxovr_clr;
  logic [7:0]       rxdr;
  logic             rxne;
  logic             rxovr;
  logic             rxmsgend;
  logic             rxerr;
  logic [9:0]       rx_paysz;
  logic             rx_busy;
  logic [CNT_W-1:0] fifo_level;

  modport slave (
    input  ucpden, rx_sop, rx_byte_vld, rx_byte, rx_eop, rx_crc_ok,
           rx_hrst_det, rxdr_rd, rxmsgend_clr, rxovr_clr,
    output rxdr, rxne, rxovr, rxmsgend, rxerr, rx_paysz, rx_busy, fifo_level
  );

  modport master (
    output ucpden, rx_sop, rx_byte_vld, rx_byte, rx_eop, rx_crc_ok,
           rx_hrst_det, rxdr_rd, rxmsgend_clr, rxovr_clr,
    input  rxdr, rxne, rxovr, rxmsgend, rxerr, rx_paysz, rx_busy, fifo_level
  );
endinterface

`default_nettype wire

// File: rtl/apb_ucpd_sync_fifo.sv
// ============================================================================
// Module  : apb_ucpd_sync_fifo
// Brief   : Single-clock FIFO with registered head output and sync flush.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_ucpd_sync_fifo #(
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3,
  parameter int DATA_W = 8
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              i_flush,
  input  wire logic              i_push,
  input  wire logic [DATA_W-1:0] i_wdata,
  input  wire logic              i_pop,
  output logic                   o_push_acc,
  output logic      [DATA_W-1:0] o_head,
  output logic      [CNT_W-1:0]  o_level,
  output logic                   o_empty
);
  localparam int               C_PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] C_FULL  = CNT_W'(DEPTH);

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [C_PTR_W-1:0] r_wr_ptr, r_rd_ptr, w_rd_nxt;
  logic [CNT_W-1:0]   r_level, w_level_nxt;
  logic [DATA_W-1:0]  r_head;
  logic               w_full, w_pop_acc, w_push_acc;

  assign o_empty    = (r_level == '0);
  assign w_full     = (r_level == C_FULL);
  assign w_pop_acc  = i_pop & ~o_empty & ~i_flush;
  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign w_push_acc = i_push & ~i_flush & (~w_full | w_pop_acc);
  assign w_rd_nxt   = r_rd_ptr + C_PTR_W'(w_pop_acc);
  assign o_push_acc = w_push_acc;
  assign o_level    = r_level;
  assign o_head     = r_head;

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push_acc, w_pop_acc})
      2'b10:   w_level_nxt = r_level + CNT_W'(1);
      2'b01:   w_level_nxt = r_level - CNT_W'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push_acc) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + C_PTR_W'(w_push_acc);
      r_rd_ptr <= w_rd_nxt;
      r_level  <= w_level_nxt;
    end
  end

  // Head bypasses the array when the new head is the byte written this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
    end else if (!i_flush && (w_level_nxt != '0)) begin
      r_head <= (w_push_acc && (w_rd_nxt == r_wr_ptr)) ? i_wdata : r_mem[w_rd_nxt];
    end
  end
endmodule

`default_nettype wire

// File: rtl/apb_ucpd_rx_buf.sv
// ============================================================================
// Module  : apb_ucpd_rx_buf
// Brief   : UCPD receive byte buffer with message framing and status flags.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_ucpd_rx_buf
  import apb_ucpd_pkg::*;
#(
  parameter int DEPTH = C_RX_DEPTH_DEF,
  parameter int CNT_W = 3
) (
  input wire logic          ic_clk,
  input wire logic          ic_rst,
  apb_ucpd_rx_buf_if.slave  bus
);
  logic [C_RXB_ST_W-1:0]   r_state, w_state_nxt;
  logic [C_RX_PAYSZ_W-1:0] r_paysz;
  logic                    r_rxovr, r_rxerr_lat;
  logic                    w_clr_all, w_in_idle, w_in_recv, w_in_drain, w_in_done;
  logic                    w_push_req, w_push_acc, w_flush, w_sop_ok, w_ovr_set, w_empty;
  logic [CNT_W-1:0]        w_level;

  assign w_clr_all  = ic_rst | ~bus.ucpden;
  assign w_in_idle  = (r_state == C_RXB_IDLE);
  assign w_in_recv  = (r_state == C_RXB_RECV);
  assign w_in_drain = (r_state == C_RXB_DRAIN);
  assign w_in_done  = (r_state == C_RXB_DONE);
  assign w_push_req = w_in_recv & bus.rx_byte_vld & ~bus.rx_hrst_det;
  assign w_flush    = (w_in_recv | w_in_drain) & bus.rx_hrst_det;
  assign w_sop_ok   = w_in_idle & bus.rx_sop;
  assign w_ovr_set  = (w_push_req & ~w_push_acc) | (bus.rx_sop & ~w_in_idle);

  apb_ucpd_sync_fifo #(
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W),
    .DATA_W (8)
  ) u_fifo (
    .clk        (ic_clk),
    .rst        (w_clr_all),
    .i_flush    (w_flush),
    .i_push     (w_push_req),
    .i_wdata    (bus.rx_byte),
    .i_pop      (bus.rxdr_rd),
    .o_push_acc (w_push_acc),
    .o_head     (bus.rxdr),
    .o_level    (w_level),
    .o_empty    (w_empty)
  );

  always_ff @(posedge ic_clk) begin
    if (w_clr_all) r_state <= C_RXB_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      C_RXB_IDLE:  if (bus.rx_sop) w_state_nxt = C_RXB_RECV;
      C_RXB_RECV:  if (bus.rx_hrst_det) w_state_nxt = C_RXB_IDLE;
                   else if (bus.rx_eop) w_state_nxt = C_RXB_DRAIN;
      C_RXB_DRAIN: if (bus.rx_hrst_det) w_state_nxt = C_RXB_IDLE;
                   else if (w_empty) w_state_nxt = C_RXB_DONE;
      C_RXB_DONE:  if (bus.rxmsgend_clr) w_state_nxt = C_RXB_IDLE;
      default:     w_state_nxt = C_RXB_IDLE;
    endcase
  end

  always_comb begin
    bus.rxmsgend   = w_in_done;
    bus.rxerr      = w_in_done & r_rxerr_lat;
    bus.rx_busy    = ~w_in_idle;
    bus.rxne       = ~w_empty;
    bus.rxovr      = r_rxovr;
    bus.rx_paysz   = r_paysz;
    bus.fifo_level = w_level;
  end

  always_ff @(posedge ic_clk) begin
    if (w_clr_all) begin
      r_paysz     <= '0;
      r_rxerr_lat <= 1'b0;
    end else begin
      if (w_sop_ok) r_paysz <= '0;
      else if (w_push_acc && (r_paysz != C_RX_PAYSZ_MAX)) r_paysz <= r_paysz + 10'd1;
      if (w_sop_ok || (w_in_done && bus.rxmsgend_clr)) r_rxerr_lat <= 1'b0;
      else if (w_in_recv && bus.rx_eop && !bus.rx_hrst_det) r_rxerr_lat <= ~bus.rx_crc_ok;
    end
  end

  // Set has priority over a coincident software clear.
  always_ff @(posedge ic_clk) begin
    if (w_clr_all)          r_rxovr <= 1'b0;
    else if (w_ovr_set)     r_rxovr <= 1'b1;
    else if (bus.rxovr_clr) r_rxovr <= 1'b0;
  end
endmodule

`default_nettype wire

// File: tb/tb_apb_ucpd_rx_buf.sv
// ============================================================================
// Module  : tb_apb_ucpd_rx_buf
// Brief   : Directed self-checking bench for the UCPD receive buffer.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_ucpd_rx_buf;
  logic ic_clk = 1'b0;
  logic ic_rst;
  int   n_total = 0;
  int   n_fail  = 0;

  apb_ucpd_rx_buf_if #(.CNT_W(3)) bus ();

  apb_ucpd_rx_buf #(.DEPTH(4), .CNT_W(3)) dut (
    .ic_clk (ic_clk),
    .ic_rst (ic_rst),
    .bus    (bus)
  );

  always #5 ic_clk = ~ic_clk;

  task automatic tick();
    @(posedge ic_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    bus.rx_byte_vld = 1'b1;
    bus.rx_byte     = b;
    tick();
    bus.rx_byte_vld = 1'b0;
  endtask

  task automatic sop();
    bus.rx_sop = 1'b1;
    tick();
    bus.rx_sop = 1'b0;
  endtask

  task automatic pop();
    bus.rxdr_rd = 1'b1;
    tick();
    bus.rxdr_rd = 1'b0;
  endtask

  initial begin
    ic_rst           = 1'b1;
    bus.ucpden       = 1'b1;
    bus.rx_sop       = 1'b0;
    bus.rx_byte_vld  = 1'b0;
    bus.rx_byte      = 8'h00;
    bus.rx_eop       = 1'b0;
    bus.rx_crc_ok    = 1'b0;
    bus.rx_hrst_det  = 1'b0;
    bus.rxdr_rd      = 1'b0;
    bus.rxmsgend_clr = 1'b0;
    bus.rxovr_clr    = 1'b0;
    tick();
    tick();
    check("rst_rxdr",  bus.rxdr, 16'h00);
    check("rst_rxne",  bus.rxne, 16'h0);
    check("rst_rxovr", bus.rxovr, 16'h0);
    check("rst_msgend", bus.rxmsgend, 16'h0);
    check("rst_paysz", bus.rx_paysz, 16'h0);
    check("rst_busy",  bus.rx_busy, 16'h0);
    check("rst_level", bus.fifo_level, 16'h0);
    ic_rst = 1'b0;
    tick();

    // Basic two-byte message.
    sop();
    check("b_busy", bus.rx_busy, 16'h1);
    push(8'hA1);
    check("b_rxne", bus.rxne, 16'h1);
    check("b_head1", bus.rxdr, 16'hA1);
    push(8'hB2);
    check("b_level2", bus.fifo_level, 16'h2);
    check("b_paysz", bus.rx_paysz, 16'h2);
    bus.rx_eop = 1'b1; bus.rx_crc_ok = 1'b1;
    tick();
    bus.rx_eop = 1'b0;
    check("b_msgend_early", bus.rxmsgend, 16'h0);
    pop();
    check("b_head2", bus.rxdr, 16'hB2);
    pop();
    check("b_empty", bus.rxne, 16'h0);
    check("b_msgend_pop", bus.rxmsgend, 16'h0);
    tick();
    check("b_msgend", bus.rxmsgend, 16'h1);
    check("b_rxerr", bus.rxerr, 16'h0);
    check("b_hold", bus.rxdr, 16'hB2);
    bus.rxmsgend_clr = 1'b1;
    tick();
    bus.rxmsgend_clr = 1'b0;
    check("b_idle", bus.rx_busy, 16'h0);
    check("b_paysz_hold", bus.rx_paysz, 16'h2);

    // Overrun: five pushes into a four-entry FIFO.
    sop();
    check("o_paysz_clr", bus.rx_paysz, 16'h0);
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    check("o_ovr_pre", bus.rxovr, 16'h0);
    push(8'h55);
    check("o_level", bus.fifo_level, 16'h4);
    check("o_rxovr", bus.rxovr, 16'h1);
    check("o_paysz", bus.rx_paysz, 16'h4);
    check("o_head1", bus.rxdr, 16'h11);
    bus.rx_eop = 1'b1; bus.rx_crc_ok = 1'b1;
    tick();
    bus.rx_eop = 1'b0;
    pop(); check("o_head2", bus.rxdr, 16'h22);
    pop(); check("o_head3", bus.rxdr, 16'h33);
    pop(); check("o_head4", bus.rxdr, 16'h44);
    pop(); check("o_drained", bus.fifo_level, 16'h0);
    check("o_last", bus.rxdr, 16'h44);
    pop(); check("o_underflow", bus.fifo_level, 16'h0);
    check("o_msgend", bus.rxmsgend, 16'h1);
    bus.rxovr_clr = 1'b1; bus.rxmsgend_clr = 1'b1;
    tick();
    bus.rxovr_clr = 1'b0; bus.rxmsgend_clr = 1'b0;
    check("o_ovr_clr", bus.rxovr, 16'h0);
    check("o_idle", bus.rx_busy, 16'h0);

    // CRC error with last byte coincident with EOP.
    sop();
    push(8'h5A);
    bus.rx_byte_vld = 1'b1; bus.rx_byte = 8'hC3;
    bus.rx_eop = 1'b1; bus.rx_crc_ok = 1'b0;
    tick();
    bus.rx_byte_vld = 1'b0; bus.rx_eop = 1'b0;
    check("c_level", bus.fifo_level, 16'h2);
    check("c_paysz", bus.rx_paysz, 16'h2);
    pop(); check("c_head2", bus.rxdr, 16'hC3);
    pop();
    tick();
    check("c_msgend", bus.rxmsgend, 16'h1);
    check("c_rxerr", bus.rxerr, 16'h1);
    bus.rxmsgend_clr = 1'b1;
    tick();
    bus.rxmsgend_clr = 1'b0;
    check("c_busy", bus.rx_busy, 16'h0);
    check("c_rxerr_clr", bus.rxerr, 16'h0);

    // Hard-reset abort with three bytes buffered.
    sop();
    push(8'h01); push(8'h02); push(8'h03);
    check("h_level3", bus.fifo_level, 16'h3);
    bus.rx_hrst_det = 1'b1;
    tick();
    bus.rx_hrst_det = 1'b0;
    check("h_level", bus.fifo_level, 16'h0);
    check("h_rxne", bus.rxne, 16'h0);
    check("h_busy", bus.rx_busy, 16'h0);
    tick();
    check("h_msgend", bus.rxmsgend, 16'h0);

    // Full FIFO with simultaneous pop and push.
    sop();
    push(8'h10); push(8'h20); push(8'h30); push(8'h40);
    bus.rxdr_rd = 1'b1;
    push(8'h50);
    bus.rxdr_rd = 1'b0;
    check("f_level", bus.fifo_level, 16'h4);
    check("f_rxovr", bus.rxovr, 16'h0);
    check("f_head", bus.rxdr, 16'h20);
    check("f_paysz", bus.rx_paysz, 16'h5);
    bus.rx_eop = 1'b1; bus.rx_crc_ok = 1'b1;
    tick();
    bus.rx_eop = 1'b0;
    pop(); pop(); pop();
    check("f_tail", bus.rxdr, 16'h50);
    pop();
    tick();
    check("f_msgend", bus.rxmsgend, 16'h1);
    bus.rxmsgend_clr = 1'b1;
    tick();
    bus.rxmsgend_clr = 1'b0;

    // Reset mid-message with overrun flagged by a stray SOP.
    sop();
    push(8'hAA); push(8'hBB);
    sop();
    check("r_ovr_sop", bus.rxovr, 16'h1);
    check("r_busy_sop", bus.rx_busy, 16'h1);
    check("r_level_sop", bus.fifo_level, 16'h2);
    ic_rst = 1'b1;
    tick();
    ic_rst = 1'b0;
    check("r_rxdr", bus.rxdr, 16'h00);
    check("r_rxne", bus.rxne, 16'h0);
    check("r_rxovr", bus.rxovr, 16'h0);
    check("r_paysz", bus.rx_paysz, 16'h0);
    check("r_busy", bus.rx_busy, 16'h0);
    check("r_level", bus.fifo_level, 16'h0);
    sop();
    check("r_restart", bus.rx_busy, 16'h1);
    check("r_restart_paysz", bus.rx_paysz, 16'h0);
    push(8'h77);
    check("r_new_head", bus.rxdr, 16'h77);
    check("r_new_paysz", bus.rx_paysz, 16'h1);

    // Disable acts as reset and clears the overrun flag too.
    sop();
    check("u_ovr", bus.rxovr, 16'h1);
    bus.ucpden = 1'b0;
    tick();
    bus.ucpden = 1'b1;
    check("u_rxovr", bus.rxovr, 16'h0);
    check("u_level", bus.fifo_level, 16'h0);
    check("u_busy", bus.rx_busy, 16'h0);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end
endmodule

`default_nettype wire
